// File: rtl/bus_xbar_rr_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bus_xbar_rr_pkg
// Purpose : Shared constants and helpers for the round-robin bus crossbar.
//           Contains default widths, the legal NUM_M/NUM_S ranges, the
//           inactive level of the active-low grant/chip-select lines and the
//           modular rotation helper used by the arbiter scan.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package bus_xbar_rr_pkg;

   localparam int unsigned c_DEF_NUM_M       = 4;
   localparam int unsigned c_DEF_NUM_S       = 8;
   localparam int unsigned c_DEF_ADDR_W      = 30;
   localparam int unsigned c_DEF_DATA_W      = 32;
   localparam int unsigned c_DEF_TIMEOUT_CYC = 256;

   localparam int unsigned c_NUM_M_MIN = 2;
   localparam int unsigned c_NUM_M_MAX = 8;
   localparam int unsigned c_NUM_S_MIN = 2;
   localparam int unsigned c_NUM_S_MAX = 16;

   // Level of a grant or chip-select line that is not asserted.
   localparam logic c_INACTIVE = 1'b1;

   // (base + step) mod n for step < n, without a divider.
   function automatic int unsigned f_rr_next(input int unsigned base,
                                             input int unsigned step,
                                             input int unsigned n);
      int unsigned s;
      s = base + step;
      return (s >= n) ? (s - n) : s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bus_xbar_rr_if.sv
`default_nettype none
// ============================================================================
// Module  : bus_xbar_rr_if
// Purpose : Bundle of all master-side and slave-side bus signals of the
//           crossbar. Active-low lines carry an _n suffix.
// Modports: xbar   - the crossbar itself
//           master - the master population (requests, strobes, write data)
//           slave  - the slave population (read data, ready)
// Signals : m_req_n/m_as_n/m_rw [NUM_M], m_addr [NUM_M*ADDR_W],
//           m_wr_data [NUM_M*DATA_W], m_grnt_n [NUM_M], m_rd_data, m_rdy_n,
//           m_err, s_addr, s_as_n, s_rw, s_wr_data, s_rd_data [NUM_S*DATA_W],
//           s_rdy_n [NUM_S], s_cs_n [NUM_S]
// Rev     : 1.0  initial release
// ============================================================================
interface bus_xbar_rr_if
   import bus_xbar_rr_pkg::*;
#(
   parameter int unsigned NUM_M  = c_DEF_NUM_M,
   parameter int unsigned NUM_S  = c_DEF_NUM_S,
   parameter int unsigned ADDR_W = c_DEF_ADDR_W,
   parameter int unsigned DATA_W = c_DEF_DATA_W
) ();

   logic [NUM_M-1:0]        m_req_n;
   logic [NUM_M*ADDR_W-1:0] m_addr;
   logic [NUM_M-1:0]        m_as_n;
   logic [NUM_M-1:0]        m_rw;
   logic [NUM_M*DATA_W-1:0] m_wr_data;
   logic [NUM_M-1:0]        m_grnt_n;
   logic [DATA_W-1:0]       m_rd_data;
   logic                    m_rdy_n;
   logic                    m_err;

   logic [ADDR_W-1:0]       s_addr;
   logic                    s_as_n;
   logic                    s_rw;
   logic [DATA_W-1:0]       s_wr_data;
   logic [NUM_S*DATA_W-1:0] s_rd_data;
   logic [NUM_S-1:0]        s_rdy_n;
   logic [NUM_S-1:0]        s_cs_n;

   modport xbar (
      input  m_req_n, m_addr, m_as_n, m_rw, m_wr_data, s_rd_data, s_rdy_n,
      output m_grnt_n, m_rd_data, m_rdy_n, m_err,
             s_addr, s_as_n, s_rw, s_wr_data, s_cs_n
   );

   modport master (
      output m_req_n, m_addr, m_as_n, m_rw, m_wr_data,
      input  m_grnt_n, m_rd_data, m_rdy_n, m_err
   );

   modport slave (
      input  s_addr, s_as_n, s_rw, s_wr_data, s_cs_n,
      output s_rd_data, s_rdy_n
   );

endinterface
`default_nettype wire

// File: rtl/bus_xbar_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : bus_xbar_rr_arbiter
// Purpose : Round-robin arbiter with park-on-last-owner. The owner register
//           only moves when the current owner has released its request; the
//           scan then starts at owner+1 and wraps.
// Ports   : clk        in   clock
//           reset      in   synchronous active-high reset (owner -> 0)
//           m_req_n_i  in   [NUM_M] active-low requests
//           m_grnt_n_o out  [NUM_M] one-hot-low grant, decoded from owner
//           owner_o    out  index of the current owner
// Rev     : 1.0  initial release
// ============================================================================
module bus_xbar_rr_arbiter
   import bus_xbar_rr_pkg::*;
#(
   parameter int unsigned NUM_M = c_DEF_NUM_M
) (
   input  wire logic                     clk,
   input  wire logic                     reset,
   input  wire logic [NUM_M-1:0]         m_req_n_i,
   output logic      [NUM_M-1:0]         m_grnt_n_o,
   output logic      [$clog2(NUM_M)-1:0] owner_o
);

   localparam int unsigned OWN_W = $clog2(NUM_M);

   logic [OWN_W-1:0] owner_q;
   logic [OWN_W-1:0] owner_d;
   logic [OWN_W-1:0] w_cand;

   // Scanning from the farthest candidate down to owner+1 lets the nearest
   // requesting master overwrite the others, so no "found" flag is needed.
   always_comb begin
      owner_d = owner_q;
      w_cand  = owner_q;
      if (m_req_n_i[owner_q] == c_INACTIVE) begin
         for (int unsigned i = NUM_M - 1; i > 0; i--) begin
            w_cand = OWN_W'(f_rr_next(32'(owner_q), i, NUM_M));
            if (m_req_n_i[w_cand] == 1'b0) begin
               owner_d = w_cand;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q <= '0;
      end else begin
         owner_q <= owner_d;
      end
   end

   for (genvar g = 0; g < NUM_M; g++) begin : g_grant
      assign m_grnt_n_o[g] = (owner_q == OWN_W'(g)) ? ~c_INACTIVE : c_INACTIVE;
   end

   assign owner_o = owner_q;

endmodule
`default_nettype wire

// File: rtl/bus_xbar_rr.sv
`default_nettype none
// ============================================================================
// Module  : bus_xbar_rr
// Purpose : Shared-bus controller for NUM_M masters and NUM_S slaves:
//           round-robin arbiter, master mux, address decoder, slave mux and
//           an optional transfer watchdog.
// Macro   : BUS_TIMEOUT_EN - when defined, a transfer left unanswered for
//           TIMEOUT_CYC cycles is ended with m_rdy_n=0, m_err=1, data 0.
//           When undefined, m_err is 0 and transfers wait indefinitely.
// Ports   : clk     in   clock
//           reset   in   synchronous active-high reset
//           xbar_if      bus_xbar_rr_if.xbar - all master/slave bus signals
// Rev     : 1.0  initial release
// ============================================================================
module bus_xbar_rr
   import bus_xbar_rr_pkg::*;
#(
   parameter int unsigned NUM_M       = c_DEF_NUM_M,
   parameter int unsigned NUM_S       = c_DEF_NUM_S,
   parameter int unsigned ADDR_W      = c_DEF_ADDR_W,
   parameter int unsigned DATA_W      = c_DEF_DATA_W,
   parameter int unsigned TIMEOUT_CYC = c_DEF_TIMEOUT_CYC
) (
   input  wire logic   clk,
   input  wire logic   reset,
   bus_xbar_rr_if.xbar xbar_if
);

   localparam int unsigned OWN_W = $clog2(NUM_M);
   localparam int unsigned SEL_W = $clog2(NUM_S);

   if ((NUM_M < c_NUM_M_MIN) || (NUM_M > c_NUM_M_MAX) ||
       (NUM_S < c_NUM_S_MIN) || (NUM_S > c_NUM_S_MAX) ||
       ((NUM_S & (NUM_S - 1)) != 0) || (ADDR_W < SEL_W) ||
       (TIMEOUT_CYC < 2)) begin : g_param_check
      $error("bus_xbar_rr: illegal parameter set");
   end

   logic [OWN_W-1:0]  w_owner;
   logic [ADDR_W-1:0] w_s_addr;
   logic              w_s_as_n;
   logic              w_s_rw;
   logic [DATA_W-1:0] w_s_wr_data;
   logic [SEL_W-1:0]  w_sel;
   logic [DATA_W-1:0] w_sel_data;
   logic              w_sel_rdy_n;
   logic              w_timeout;

   bus_xbar_rr_arbiter #(
      .NUM_M (NUM_M)
   ) u_arbiter (
      .clk        (clk),
      .reset      (reset),
      .m_req_n_i  (xbar_if.m_req_n),
      .m_grnt_n_o (xbar_if.m_grnt_n),
      .owner_o    (w_owner)
   );

   // Master mux: forward the owner's address phase to the slave side.
   always_comb begin
      w_s_addr    = '0;
      w_s_as_n    = 1'b1;
      w_s_rw      = 1'b0;
      w_s_wr_data = '0;
      for (int unsigned i = 0; i < NUM_M; i++) begin
         if (w_owner == OWN_W'(i)) begin
            w_s_addr    = xbar_if.m_addr[i*ADDR_W +: ADDR_W];
            w_s_as_n    = xbar_if.m_as_n[i];
            w_s_rw      = xbar_if.m_rw[i];
            w_s_wr_data = xbar_if.m_wr_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Decoder: top address bits pick the slave; chip select ignores the strobe.
   assign w_sel = w_s_addr[ADDR_W-1 -: SEL_W];

   for (genvar g = 0; g < NUM_S; g++) begin : g_cs
      assign xbar_if.s_cs_n[g] = (w_sel == SEL_W'(g)) ? ~c_INACTIVE : c_INACTIVE;
   end

   // Slave mux.
   always_comb begin
      w_sel_data  = '0;
      w_sel_rdy_n = 1'b1;
      for (int unsigned j = 0; j < NUM_S; j++) begin
         if (w_sel == SEL_W'(j)) begin
            w_sel_data  = xbar_if.s_rd_data[j*DATA_W +: DATA_W];
            w_sel_rdy_n = xbar_if.s_rdy_n[j];
         end
      end
   end

`ifdef BUS_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

   logic [CNT_W-1:0] wdog_q;
   logic [CNT_W-1:0] wdog_d;
   logic             w_owner_chg;

   // The owner moves at the next edge exactly when it has released and some
   // other master is requesting; clearing then gives the new owner a full window.
   assign w_owner_chg = xbar_if.m_req_n[w_owner] & ~(&xbar_if.m_req_n);

   // A ready slave in the terminal cycle takes precedence over the watchdog.
   assign w_timeout = ~w_s_as_n & w_sel_rdy_n &
                      (wdog_q == CNT_W'(TIMEOUT_CYC - 1));

   always_comb begin
      wdog_d = wdog_q + CNT_W'(1);
      if (w_s_as_n || !w_sel_rdy_n || w_timeout || w_owner_chg) begin
         wdog_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_d;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   assign xbar_if.s_addr    = w_s_addr;
   assign xbar_if.s_as_n    = w_s_as_n;
   assign xbar_if.s_rw      = w_s_rw;
   assign xbar_if.s_wr_data = w_s_wr_data;

   assign xbar_if.m_rdy_n   = w_s_as_n  ? 1'b1 :
                              w_timeout ? 1'b0 : w_sel_rdy_n;
   assign xbar_if.m_err     = w_timeout;
   assign xbar_if.m_rd_data = w_timeout ? '0 : w_sel_data;

endmodule
`default_nettype wire

// File: tb/tb_bus_xbar_rr.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_xbar_rr
// Purpose : Directed self-checking bench for bus_xbar_rr (NUM_M=4, NUM_S=8,
//           ADDR_W=30, DATA_W=32, TIMEOUT_CYC=16). Watchdog steps are built
//           only when BUS_TIMEOUT_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
module tb_bus_xbar_rr;

   localparam int unsigned NM = 4;
   localparam int unsigned NS = 8;
   localparam int unsigned AW = 30;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 16;

   localparam logic [AW-1:0] A0 = 30'h0000_0100;   // slave 0
   localparam logic [AW-1:0] A1 = 30'h0800_0004;   // slave 1
   localparam logic [AW-1:0] A2 = 30'h3800_0000;   // slave 7
   localparam logic [AW-1:0] A3 = 30'h1000_0008;   // slave 2
   localparam logic [DW-1:0] WD2 = 32'h2222_0002;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   bus_xbar_rr_if #(.NUM_M(NM), .NUM_S(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

   bus_xbar_rr #(
      .NUM_M       (NM),
      .NUM_S       (NS),
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .xbar_if (bus)
   );

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic push(input string tag, input logic [63:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb_q.push_back(e);
   endtask

   task automatic pop_chk(input logic [63:0] obs);
      exp_t e;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $error("FAIL sb_underflow observed=%0h expected=none", obs);
      end else begin
         e = sb_q.pop_front();
         check(e.tag, obs, e.val);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   function automatic logic [DW-1:0] sdata(input int unsigned j);
      return 32'hC0DE_0000 + j;
   endfunction

   int       bad;
   logic [NM-1:0] last;

   initial begin
      reset          = 1'b1;
      bus.m_req_n    = '1;
      bus.m_as_n     = '1;
      bus.m_rw       = '0;
      bus.m_addr     = {A3, A2, A1, A0};
      bus.m_wr_data  = {32'h3333_0003, WD2, 32'h1111_0001, 32'hAAAA_0000};
      bus.s_rdy_n    = '1;
      for (int j = 0; j < NS; j++) bus.s_rd_data[j*DW +: DW] = sdata(j);

      // ---- reset state ----
      next_cyc();
      next_cyc();
      reset = 1'b0;
      settle();
      push("rst_grnt", 64'hE);
      push("rst_s_addr", 64'(A0));
      push("rst_cs", 64'hFE);
      push("rst_rdy", 64'h1);
      push("rst_err", 64'h0);
      pop_chk(64'(bus.m_grnt_n));
      pop_chk(64'(bus.s_addr));
      pop_chk(64'(bus.s_cs_n));
      pop_chk(64'(bus.m_rdy_n));
      pop_chk(64'(bus.m_err));

      // ---- round robin ----
      bus.m_req_n = 4'b1110;
      next_cyc(); settle();
      push("rr_m0_own", 64'hE);
      pop_chk(64'(bus.m_grnt_n));

      bus.m_req_n = 4'b0000;
      bad = 0;
      repeat (3) begin
         next_cyc(); settle();
         if (bus.m_grnt_n !== 4'b1110) bad++;
      end
      push("rr_m0_hold", 64'h0);
      pop_chk(64'(bad));

      bus.m_req_n = 4'b0001;
      push("rr_grant_m1", 64'hD);
      push("rr_grant_m2", 64'hB);
      push("rr_grant_m3", 64'h7);
      last = bus.m_grnt_n;
      for (int c = 0; c < 12 && sb_q.size() > 0; c++) begin
         next_cyc(); settle();
         if (bus.m_grnt_n !== last) begin
            last = bus.m_grnt_n;
            pop_chk(64'(last));
            bus.m_req_n = bus.m_req_n | ~last;   // new owner releases at once
         end
      end
      check("rr_all_granted", 64'(sb_q.size()), 64'h0);
      sb_q.delete();
      repeat (2) next_cyc();
      settle();
      push("rr_park_m3", 64'h7);
      pop_chk(64'(bus.m_grnt_n));

      // ---- hold and park ----
      bus.m_req_n = 4'b1011;
      next_cyc(); settle();
      push("hold_grant_m2", 64'hB);
      pop_chk(64'(bus.m_grnt_n));

      bus.m_req_n = 4'b0000;
      bad = 0;
      repeat (50) begin
         next_cyc(); settle();
         if (bus.m_grnt_n !== 4'b1011) bad++;
      end
      push("hold_50_cycles", 64'h0);
      pop_chk(64'(bad));

      bus.m_req_n = '1;
      repeat (3) next_cyc();
      settle();
      push("park_m2", 64'hB);
      pop_chk(64'(bus.m_grnt_n));

      // ---- decode and slave mux (owner m2, address 30'h3800_0000) ----
      bus.m_rw   = 4'b0100;
      bus.m_as_n = 4'b1011;
      bus.s_rdy_n = 8'hFF;
      settle();
      push("dec_s_addr", 64'(A2));
      push("dec_cs", 64'h7F);
      push("dec_s_rw", 64'h1);
      push("dec_s_as", 64'h0);
      push("dec_wr_data", 64'(WD2));
      push("dec_rd_data", 64'(sdata(7)));
      push("dec_rdy_wait", 64'h1);
      pop_chk(64'(bus.s_addr));
      pop_chk(64'(bus.s_cs_n));
      pop_chk(64'(bus.s_rw));
      pop_chk(64'(bus.s_as_n));
      pop_chk(64'(bus.s_wr_data));
      pop_chk(64'(bus.m_rd_data));
      pop_chk(64'(bus.m_rdy_n));

      bus.s_rdy_n = 8'h7F;
      settle();
      push("dec_rdy", 64'h0);
      push("dec_err", 64'h0);
      pop_chk(64'(bus.m_rdy_n));
      pop_chk(64'(bus.m_err));

      bus.s_rdy_n = 8'hF7;
      settle();
      push("dec_other_rdy", 64'h1);
      pop_chk(64'(bus.m_rdy_n));

      bus.m_as_n  = '1;
      bus.s_rdy_n = 8'h7F;
      settle();
      push("dec_rdy_no_as", 64'h1);
      push("dec_cs_no_as", 64'h7F);
      pop_chk(64'(bus.m_rdy_n));
      pop_chk(64'(bus.s_cs_n));

      bus.s_rdy_n = '1;
      next_cyc();

`ifdef BUS_TIMEOUT_EN
      // ---- watchdog: silent slave ----
      bus.m_as_n = 4'b1011;
      for (int c = 1; c <= 20; c++) begin
         settle();
         push($sformatf("to_rdy_c%0d", c), (c == 16) ? 64'h0 : 64'h1);
         push($sformatf("to_err_c%0d", c), (c == 16) ? 64'h1 : 64'h0);
         pop_chk(64'(bus.m_rdy_n));
         pop_chk(64'(bus.m_err));
         if (c == 16) begin
            push("to_data_zero", 64'h0);
            pop_chk(64'(bus.m_rd_data));
         end
         next_cyc();
      end
      bus.m_as_n = '1;
      next_cyc();

      // ---- watchdog: slave answers in the terminal cycle ----
      bus.m_as_n = 4'b1011;
      bad = 0;
      for (int c = 1; c <= 15; c++) begin
         settle();
         if (bus.m_err !== 1'b0 || bus.m_rdy_n !== 1'b1) bad++;
         next_cyc();
      end
      push("win_pre_cycles", 64'h0);
      pop_chk(64'(bad));
      bus.s_rdy_n = 8'h7F;
      settle();
      push("win_rdy", 64'h0);
      push("win_err", 64'h0);
      push("win_data", 64'(sdata(7)));
      pop_chk(64'(bus.m_rdy_n));
      pop_chk(64'(bus.m_err));
      pop_chk(64'(bus.m_rd_data));
      bus.s_rdy_n = '1;
      bus.m_as_n  = '1;
      next_cyc();

      // ---- reset at count 10 ----
      bus.m_as_n = 4'b1011;
      repeat (10) next_cyc();
      reset      = 1'b1;
      bus.m_as_n = 4'b1110;   // master 0 keeps a strobe across the reset
      next_cyc();
      reset = 1'b0;
      settle();
      push("rm_grnt", 64'hE);
      pop_chk(64'(bus.m_grnt_n));
      bad = 0;
      for (int c = 1; c <= 15; c++) begin
         settle();
         if (bus.m_err !== 1'b0) bad++;
         next_cyc();
      end
      push("rm_no_err", 64'h0);
      pop_chk(64'(bad));
      settle();
      push("rm_fresh_timeout", 64'h1);
      pop_chk(64'(bus.m_err));
`else
      // ---- no watchdog: an unanswered transfer just waits ----
      bus.m_as_n = 4'b1011;
      bad = 0;
      repeat (20) begin
         settle();
         if (bus.m_rdy_n !== 1'b1 || bus.m_err !== 1'b0) bad++;
         next_cyc();
      end
      push("wait_forever", 64'h0);
      pop_chk(64'(bad));

      // ---- reset mid-transfer ----
      reset      = 1'b1;
      bus.m_as_n = 4'b1110;
      next_cyc();
      reset = 1'b0;
      settle();
      push("rm_grnt", 64'hE);
      push("rm_s_as", 64'h0);
      push("rm_s_addr", 64'(A0));
      push("rm_err", 64'h0);
      pop_chk(64'(bus.m_grnt_n));
      pop_chk(64'(bus.s_as_n));
      pop_chk(64'(bus.s_addr));
      pop_chk(64'(bus.m_err));
`endif

      bus.m_as_n = '1;
      next_cyc();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
